sync_timing_generator: RTL and testbench
========================================

// Module: sync_timing_generator
// PURPOSE
//  Generates the video timing that the overlay path consumes: active-low composite sync
//  (csync) and vertical sync (vsync) pulses.
//  Also exports the live column/line position, clocked on the 4 MHz pixel clock.
//  Drives the bench/pattern path in place of the external sync separator.
//  Overlay logic that counts csync/vsync edges sees the same positions this block reports.
// PARAMETERS
//  H_TOTAL      254  clocks per line (63.5 us @ 4 MHz); 16..1023
//  H_SYNC       19   clocks of horizontal sync pulse (~4.7 us); 1..H_TOTAL/2-1
//  V_TOTAL      262  lines per field; 8..1023
//  V_SYNC_LINES 3    lines carrying vertical sync (broad pulses); 1..V_TOTAL-1
// PORTS
//  clk4mhz       in   1   pixel clock; all state on rising edge
//  reset_n       in   1   asynchronous, active-low reset
//  run           in   1   1 = generate timing; 0 = hold idle
//  csync         out  1   composite sync, active low
//  vsync         out  1   vertical sync, active low
//  column_count  out  10  current column, 0..H_TOTAL-1
//  line_count    out  10  current line, 0..V_TOTAL-1
//  frame_start   out  1   one-clock pulse at column 0 of line 0
// BEHAVIOUR
//  Reset: column_count=0, line_count=0, csync=1, vsync=1, frame_start=0 (and blank=1 if enabled).
//  States: IDLE, ACTIVE. Reset enters IDLE.
//   IDLE -> ACTIVE when run=1.
//   ACTIVE -> IDLE when run=0.
//  IDLE: counters forced 0; csync=1, vsync=1, frame_start=0.
//  ACTIVE counting:
//   - column_count increments every clock.
//   - At H_TOTAL-1 the column wraps to 0 and line_count increments.
//   - At V_TOTAL-1 with column H_TOTAL-1, the line wraps to 0.
//   - Counters are unsigned 10-bit and never exceed TOTAL-1.
//  All outputs are registered and aligned to the counts on the same clock.
//   - They are decoded from the next-state counts: zero relative latency between counts and syncs.
//  Sync decode for the current (line L, column C):
//   - L < V_SYNC_LINES: vsync=0, and csync=0 while C < H_TOTAL-H_SYNC (broad pulse), else 1.
//   - Otherwise: vsync=1, and csync=0 while C < H_SYNC, else 1.
//   - frame_start=1 only when L=0, C=0.
//  Start-up: the first ACTIVE clock after run rises shows C=0, L=0, csync=0, vsync=0, frame_start=1.
//  Mid-frame run deassert: the next clock is IDLE values. A later run=1 restarts at line 0, column 0;
//   there is no resume.
//  run toggling 1->0->1 on consecutive clocks gives one IDLE clock, then a restart.
//  Async reset mid-line: outputs go to reset values immediately. Operation resumes per run after release.
//  Illegal parameters (H_SYNC >= H_TOTAL/2, V_SYNC_LINES >= V_TOTAL): elaboration error via generate check.
// CONFIGURATION
//  SYNC_GEN_BLANK_EN defined:
//   - Adds output port blank (out, 1, active high).
//   - blank=1 when L < V_SYNC_LINES+6, or C < H_SYNC+10, or C >= H_TOTAL-6; blank=1 in IDLE.
//   - Registered and aligned like csync.
//  Not defined: no blank port and no blanking logic; all other behaviour identical.
// TESTING
//  1. Reset low, then release with run=0 for 20 clocks -> counts 0, csync=1, vsync=1, frame_start=0 throughout.
//  2. run=1 from reset, defaults:
//     - first clock: C=0, L=0, frame_start=1, csync=0, vsync=0.
//     - frame_start repeats every 254*262=66548 clocks.
//  3. Defaults, line 10: csync low for exactly 19 clocks (C=0..18), high for C=19..253; vsync=1.
//  4. Defaults, lines 0..2: csync low for C=0..234 (235 clocks), vsync low for 762 clocks; line 3 C=0 -> vsync=1.
//  5. run=0 at L=100, C=50 -> next clock C=0, L=0, csync=1; run=1 again -> frame_start on the following clock.
//  6. reset_n pulsed low at L=1, C=7 -> outputs at reset values without a clock edge.
//     With SYNC_GEN_BLANK_EN: blank=1 at L=20, C=10 and blank=0 at L=20, C=100.

Source files
------------

// File: rtl/sync_timing_generator.sv
//----------------------------------------------------------------------------
// Module   : sync_timing_generator
// Purpose  : 4 MHz composite/vertical sync generator with live column/line
//            position. Optional blank output when SYNC_GEN_BLANK_EN is defined.
// Revision : 1.0  initial release
//----------------------------------------------------------------------------
`default_nettype none

module sync_timing_generator #(
  parameter int H_TOTAL      = 254,
  parameter int H_SYNC       = 19,
  parameter int V_TOTAL      = 262,
  parameter int V_SYNC_LINES = 3
) (
  input  logic       clk4mhz,
  input  logic       reset_n,
  input  logic       run,
  output logic       csync,
  output logic       vsync,
  output logic [9:0] column_count,
  output logic [9:0] line_count,
  output logic       frame_start
`ifdef SYNC_GEN_BLANK_EN
  ,
  output logic       blank
`endif
);

  if ((H_TOTAL < 16) || (H_TOTAL > 1023) || (V_TOTAL < 8) || (V_TOTAL > 1023) ||
      (H_SYNC < 1) || (H_SYNC >= H_TOTAL / 2) ||
      (V_SYNC_LINES < 1) || (V_SYNC_LINES >= V_TOTAL)) begin : g_badParams
    $error("sync_timing_generator: illegal timing parameters");
  end

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam logic [9:0] c_hLast      = 10'(H_TOTAL - 1);
  localparam logic [9:0] c_vLast      = 10'(V_TOTAL - 1);
  localparam logic [9:0] c_hSync      = 10'(H_SYNC);
  localparam logic [9:0] c_broadEnd   = 10'(H_TOTAL - H_SYNC);
  localparam logic [9:0] c_vSyncLines = 10'(V_SYNC_LINES);

  state_t     r_state;
  logic [9:0] w_nextCol;
  logic [9:0] w_nextLine;
  logic       w_inVsync;
  logic       w_csync;

  // Outputs are decoded from the position the counters are about to take,
  // so syncs and counts change on the same edge.
  always_comb begin
    w_nextCol  = 10'd0;
    w_nextLine = 10'd0;
    if (r_state == ACTIVE) begin
      if (column_count == c_hLast) begin
        w_nextLine = (line_count == c_vLast) ? 10'd0 : line_count + 10'd1;
      end else begin
        w_nextCol  = column_count + 10'd1;
        w_nextLine = line_count;
      end
    end
  end

  assign w_inVsync = (w_nextLine < c_vSyncLines);
  assign w_csync   = w_inVsync ? (w_nextCol >= c_broadEnd) : (w_nextCol >= c_hSync);

`ifdef SYNC_GEN_BLANK_EN
  localparam logic [10:0] c_vBlankEnd   = 11'(V_SYNC_LINES + 6);
  localparam logic [10:0] c_hBlankEnd   = 11'(H_SYNC + 10);
  localparam logic [9:0]  c_hBlankStart = 10'(H_TOTAL - 6);

  logic w_blank;
  assign w_blank = ({1'b0, w_nextLine} < c_vBlankEnd) ||
                   ({1'b0, w_nextCol} < c_hBlankEnd) ||
                   (w_nextCol >= c_hBlankStart);
`endif

  always_ff @(posedge clk4mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      column_count <= 10'd0;
      line_count   <= 10'd0;
      csync        <= 1'b1;
      vsync        <= 1'b1;
      frame_start  <= 1'b0;
`ifdef SYNC_GEN_BLANK_EN
      blank        <= 1'b1;
`endif
    end else if (!run) begin
      r_state      <= IDLE;
      column_count <= 10'd0;
      line_count   <= 10'd0;
      csync        <= 1'b1;
      vsync        <= 1'b1;
      frame_start  <= 1'b0;
`ifdef SYNC_GEN_BLANK_EN
      blank        <= 1'b1;
`endif
    end else begin
      // Leaving IDLE yields next position 0/0, which restarts the frame.
      r_state      <= ACTIVE;
      column_count <= w_nextCol;
      line_count   <= w_nextLine;
      csync        <= w_csync;
      vsync        <= !w_inVsync;
      frame_start  <= (w_nextCol == 10'd0) && (w_nextLine == 10'd0);
`ifdef SYNC_GEN_BLANK_EN
      blank        <= w_blank;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sync_timing_generator.sv
//----------------------------------------------------------------------------
// Module   : tb_sync_timing_generator
// Purpose  : Randomised self-checking bench against a frame-position model.
// Revision : 1.0  initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_sync_timing_generator;

  localparam int H     = 254;
  localparam int HS    = 19;
  localparam int V     = 262;
  localparam int VS    = 3;
  localparam int FRAME = H * V;

  logic       clk4mhz = 1'b0;
  logic       reset_n = 1'b1;
  logic       run     = 1'b0;
  logic       csync;
  logic       vsync;
  logic [9:0] column_count;
  logic [9:0] line_count;
  logic       frame_start;
`ifdef SYNC_GEN_BLANK_EN
  logic       blank;
`endif

  sync_timing_generator #(
    .H_TOTAL(H), .H_SYNC(HS), .V_TOTAL(V), .V_SYNC_LINES(VS)
  ) dut (
    .clk4mhz      (clk4mhz),
    .reset_n      (reset_n),
    .run          (run),
    .csync        (csync),
    .vsync        (vsync),
    .column_count (column_count),
    .line_count   (line_count),
    .frame_start  (frame_start)
`ifdef SYNC_GEN_BLANK_EN
    ,
    .blank        (blank)
`endif
  );

  always #5 clk4mhz = ~clk4mhz;

  int nChecks = 0;
  int nErrors = 0;
  // Model: active flag plus clocks elapsed since the frame restarted.
  bit mActive = 1'b0;
  int mT      = 0;
  int cycle   = 0;

  task automatic checkValue(input string tag, input int got, input int exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      if (nErrors <= 40)
        $display("FAIL %s cycle %0d observed %0d expected %0d", tag, cycle, got, exp);
    end
  endtask

  task automatic checkAll(input string when);
    int pos, c, l, cs, vs, fs, bl;
    if (!mActive) begin
      c = 0; l = 0; cs = 1; vs = 1; fs = 0; bl = 1;
    end else begin
      pos = mT % FRAME;
      c   = pos % H;
      l   = pos / H;
      vs  = (l < VS) ? 0 : 1;
      cs  = (l < VS) ? ((c < H - HS) ? 0 : 1) : ((c < HS) ? 0 : 1);
      fs  = (pos == 0) ? 1 : 0;
      bl  = ((l < VS + 6) || (c < HS + 10) || (c >= H - 6)) ? 1 : 0;
    end
    checkValue({when, " column"}, int'(column_count), c);
    checkValue({when, " line"}, int'(line_count), l);
    checkValue({when, " csync"}, int'(csync), cs);
    checkValue({when, " vsync"}, int'(vsync), vs);
    checkValue({when, " frame_start"}, int'(frame_start), fs);
`ifdef SYNC_GEN_BLANK_EN
    checkValue({when, " blank"}, int'(blank), bl);
`endif
  endtask

  // Advance one clock: update model from inputs seen at the edge, check at negedge.
  task automatic step();
    @(posedge clk4mhz);
    if (!reset_n) mActive = 1'b0;
    else if (run) begin
      mT      = mActive ? (mT + 1) % FRAME : 0;
      mActive = 1'b1;
    end else mActive = 1'b0;
    cycle++;
    @(negedge clk4mhz);
    checkAll("cyc");
  endtask

  task automatic asyncReset();
    reset_n = 1'b0;
    mActive = 1'b0;
    #1;
    checkAll("async reset");
  endtask

  initial begin
    int fsCycles[$];
    int csLow10, csLow0, vLow, guard, r;

    #1;
    asyncReset();
    repeat (3) step();
    reset_n = 1'b1;
    repeat (20) step();

    // Full frame plus a slice of the next, measuring pulse widths from the DUT.
    run = 1'b1;
    csLow10 = 0; csLow0 = 0; vLow = 0;
    for (int k = 0; k <= FRAME + 20 * H + 50; k++) begin
      step();
      if (frame_start) fsCycles.push_back(cycle);
      if (k < FRAME) begin
        if (line_count == 10'd10 && !csync) csLow10++;
        if (line_count == 10'd0 && !csync) csLow0++;
        if (line_count < 10'd3 && !vsync) vLow++;
      end
    end
    checkValue("frame_start count", fsCycles.size(), 2);
    if (fsCycles.size() == 2)
      checkValue("frame period", fsCycles[1] - fsCycles[0], FRAME);
    checkValue("line10 csync low", csLow10, HS);
    checkValue("line0 broad low", csLow0, H - HS);
    checkValue("vsync low clocks", vLow, VS * H);
    checkValue("mid-frame line", int'(line_count), 20);
    checkValue("mid-frame column", int'(column_count), 50);

    // Mid-frame stop then restart.
    run = 1'b0;
    step();
    checkValue("stop column", int'(column_count), 0);
    checkValue("stop csync", int'(csync), 1);
    run = 1'b1;
    step();
    checkValue("restart frame_start", int'(frame_start), 1);

    // Async reset at line 1, column 7.
    guard = 0;
    while (!(mActive && mT == H + 7) && guard < 2000) begin
      step();
      guard++;
    end
    checkValue("reach L1C7", (guard < 2000) ? 1 : 0, 1);
    asyncReset();
    checkValue("reset csync", int'(csync), 1);
    checkValue("reset vsync", int'(vsync), 1);
    repeat (2) step();
    reset_n = 1'b1;
    step();
    checkValue("post-reset frame_start", int'(frame_start), 1);

    // Random run toggling, single-clock drops and async resets.
    for (int k = 0; k < 4000; k++) begin
      r = int'($urandom_range(0, 199));
      if (r == 0) run = ~run;
      else if (r == 1 && run) begin
        run = 1'b0;
        step();
        run = 1'b1;
      end else if (r == 2) begin
        asyncReset();
        step();
        reset_n = 1'b1;
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule

`default_nettype wire
